// File: rtl/spi_slave_param.sv
// SPI slave front end: deserialises 2-bit command + DATA_W payload frames and serialises RAM read data.
// Define SPI_SLAVE_BURST_EN to allow back-to-back frames while SS_n stays low.
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              proto_err,
  output logic              timeout_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CW      = $clog2(FRAME_W + 1);
  localparam int TW      = $clog2(TX_TIMEOUT + 1);

`ifdef SPI_SLAVE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {IDLE, RX_FRAME, WAIT_TX, SHIFT_OUT, DONE} state_t;

  state_t              state;
  logic [FRAME_W-2:0]  shift_in;
  logic [DATA_W-1:0]   out_shift;
  logic [CW-1:0]       bit_cnt;
  logic [TW-1:0]       to_cnt;
  logic                rd_addr_seen;
  logic [FRAME_W-1:0]  frame_next;
  logic [1:0]          cmd;

  assign frame_next = {shift_in, MOSI};
  assign cmd        = frame_next[FRAME_W-1:FRAME_W-2];
  assign busy       = (state != IDLE);

  // tx_valid/tx_data handshake: there is no ready; the word is consumed on the
  // first edge tx_valid is high while in WAIT_TX and ignored in every other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shift_in     <= '0;
      out_shift    <= '0;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      rd_addr_seen <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      frame_err    <= 1'b0;
      proto_err    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      proto_err   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (!SS_n) begin
            state   <= RX_FRAME;
            bit_cnt <= CW'(FRAME_W);
          end
        end
        RX_FRAME: begin
          shift_in <= {shift_in[FRAME_W-3:0], MOSI};
          bit_cnt  <= bit_cnt - CW'(1);
          if (bit_cnt == CW'(1)) begin
            rx_data  <= frame_next;
            rx_valid <= 1'b1;
            if (cmd == CMD_RD_DATA && !rd_addr_seen) begin
              proto_err <= 1'b1;
              state     <= DONE;
            end else if (cmd == CMD_RD_DATA) begin
              state  <= WAIT_TX;
              to_cnt <= '0;
            end else begin
              if (cmd == CMD_RD_ADDR) rd_addr_seen <= 1'b1;
              if (BURST) begin
                state   <= RX_FRAME;
                bit_cnt <= CW'(FRAME_W);
              end else begin
                state <= DONE;
              end
            end
            // A frame whose last bit coincides with SS_n rising still counts.
            if (SS_n) begin
              state <= IDLE;
              MISO  <= 1'b0;
            end
          end else if (SS_n) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            MISO      <= 1'b0;
          end
        end
        WAIT_TX: begin
          if (SS_n) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            MISO      <= 1'b0;
          end else if (tx_valid) begin
            out_shift <= tx_data;
            MISO      <= tx_data[DATA_W-1];
            bit_cnt   <= CW'(DATA_W - 1);
            state     <= SHIFT_OUT;
          end else if (to_cnt == TW'(TX_TIMEOUT - 1)) begin
            timeout_err  <= 1'b1;
            rd_addr_seen <= 1'b0;
            MISO         <= 1'b0;
            state        <= DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        SHIFT_OUT: begin
          if (SS_n) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            MISO      <= 1'b0;
          end else if (bit_cnt == '0) begin
            MISO         <= 1'b0;
            rd_addr_seen <= 1'b0;
            if (BURST) begin
              state   <= RX_FRAME;
              bit_cnt <= CW'(FRAME_W);
            end else begin
              state <= DONE;
            end
          end else begin
            out_shift <= out_shift << 1;
            MISO      <= out_shift[DATA_W-2];
            bit_cnt   <= bit_cnt - CW'(1);
          end
        end
        DONE: begin
          MISO <= 1'b0;
          if (SS_n) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          MISO  <= 1'b0;
        end
      endcase
    end
  end

endmodule
